rv_multicycle_ctrl: RTL and testbench
=====================================

# rv_multicycle_ctrl

Main control FSM for the multicycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback over the shared single-port memory and the single ALU. Drives the write enables and mux selects for the PC, instruction register, register file, ALU operands and memory port. Traps on unsupported opcodes and on memory timeouts.

## Interface
- MAX_WAIT, 255: maximum stall cycles tolerated in FETCH or MEM before a bus-error trap. 0 disables the watchdog.
- clk  in  1  core clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction register contents; valid from DECODE onward
- mem_ready  in  1  memory completes the current request this cycle
- br_taken  in  1  branch comparator result; valid in EXEC
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  store request, qualifies mem_req
- addr_sel  out  1  memory address: 0 = PC, 1 = alu_out register
- ir_we  out  1  load instruction register
- alu_a_sel  out  2  ALU operand A: 0 = rs1, 1 = PC, 2 = zero
- alu_b_sel  out  1  ALU operand B: 0 = rs2, 1 = imm
- alu_force_add  out  1  ALU performs ADD, ignoring funct3/funct7
- pc_we  out  1  load PC
- pc_sel  out  2  next PC: 0 = PC+4, 1 = alu_out, 2 = alu_out & ~1
- rf_we  out  1  register file write
- wb_sel  out  2  writeback data: 0 = alu_out, 1 = load data, 2 = PC+4
- retire  out  1  one-cycle pulse per committed instruction
- illegal  out  1  sticky flag: illegal-opcode trap
- bus_err  out  1  sticky flag: memory-timeout trap
- state  out  3  FSM state code for debug

## Operation
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH
  - Drives mem_req=1, addr_sel=0.
  - On mem_ready, drives ir_we=1 in the same cycle and moves to DECODE. Otherwise stays in FETCH.
- DECODE
  - Lasts 1 cycle.
  - Classifies instr[6:0]. Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Any other opcode goes to TRAP with illegal=1. Otherwise the next state is EXEC.
- EXEC
  - Lasts 1 cycle. Operand selects by class:
    - OP: a=rs1, b=rs2.
    - OP-IMM, LOAD, STORE, JALR: a=rs1, b=imm.
    - LUI: a=zero, b=imm.
    - AUIPC, JAL, BRANCH: a=PC, b=imm.
  - alu_force_add=1 for every class except OP and OP-IMM.
  - br_taken is registered into taken_q.
  - Next state: LOAD and STORE go to MEM; all others go to WB.
- MEM
  - Drives mem_req=1, addr_sel=1, and mem_we=1 for STORE.
  - On mem_ready moves to WB. Otherwise stays in MEM.
- WB
  - pc_we=1 and retire=1.
  - pc_sel: JAL=1, JALR=2, BRANCH=(taken_q ? 1 : 0), all others 0.
  - rf_we=1 for OP, OP-IMM, LUI, AUIPC, LOAD, JAL and JALR, gated to 0 when instr[11:7]==0.
  - wb_sel: LOAD=1; JAL and JALR=2; all others 0.
  - Next state is FETCH.
- TRAP
  - All strobes are 0. illegal/bus_err hold their values.
  - The FSM stays in TRAP until rst.
- Watchdog
  - A wait counter clears on entry to FETCH or MEM and increments each cycle without mem_ready.
  - When the counter reaches MAX_WAIT while mem_ready is still low, the FSM goes to TRAP with bus_err=1 and drops mem_req.
- Any output not listed for a state is 0.

## Timing
- Reset
  - While rst=1, all outputs are 0, including state.
  - The next state is FETCH; taken_q, the wait counter, illegal and bus_err clear.
  - The first cycle after rst deasserts is FETCH with mem_req=1.
- Reset mid-operation
  - Abandons the instruction with no pc_we or rf_we.
  - An outstanding memory request is dropped; the memory must tolerate mem_req falling without mem_ready.
- Latency with zero-wait memory (mem_ready in the first request cycle):
  - 4 cycles for ALU, LUI, AUIPC, JAL, JALR and BRANCH.
  - 5 cycles for LOAD and STORE.
  - Each wait cycle adds 1.
- ir_we is combinational on mem_ready in FETCH. All other outputs are Moore, decoded from state and instr.
- retire spacing is at least 4 cycles.
- mem_ready outside FETCH or MEM is ignored.

## Test plan
- ADDI 0x00C00093, mem_ready always 1:
  - Required state sequence 0,1,2,4.
  - EXEC: alu_a_sel=0, alu_b_sel=1, alu_force_add=0.
  - WB: rf_we=1, wb_sel=0, pc_sel=0, retire=1.
  - Next cycle: FETCH.
- LW 0x00402083 with mem_ready held low for 3 MEM cycles:
  - MEM lasts 4 cycles with addr_sel=1 and mem_we=0.
  - WB: wb_sel=1, rf_we=1.
  - Total 8 cycles.
- SW 0x00102223, then ADDI x0 0x00C00013:
  - SW: mem_we=1 in MEM and rf_we=0 in WB.
  - ADDI x0: rf_we=0 while retire=1.
- Branch and jump:
  - BEQ 0x00100463 with br_taken=1 in EXEC (low elsewhere): pc_sel=1 in WB.
  - Same BEQ with br_taken=0: pc_sel=0.
  - JAL 0x008000EF: alu_a_sel=1 in EXEC; wb_sel=2 and pc_sel=1 in WB.
  - JALR 0x008000E7: pc_sel=2 in WB.
- Illegal opcode:
  - instr 0x00000000 fetched: DECODE goes to TRAP (state=7) with illegal=1.
  - Thereafter no mem_req, pc_we or retire for 20 cycles.
  - rst then restarts FETCH with illegal=0.
- Watchdog, MAX_WAIT=4, mem_ready stuck low in FETCH:
  - bus_err=1 and state=7 exactly after 4 stall cycles, with mem_req=0 from then on.
  - rst asserted mid-MEM: all outputs 0 during reset, no rf_we, then FETCH.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - main control FSM for the multicycle RV32I core
// Sequences fetch/decode/exec/mem/wb over one memory port and one ALU; traps on bad opcodes and bus timeouts.

module rv_multicycle_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        alu_force_add,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state
);

  localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = (MAX_WAIT > 0) ? WW'(MAX_WAIT - 1) : '0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          taken_q, taken_d;
  logic          illegal_q, illegal_d;
  logic          bus_err_q, bus_err_d;

  logic [6:0] opcode;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic       is_load, is_store, is_opimm, is_op, is_legal;
  logic       rd_nonzero;
  logic       unused_instr;

  assign opcode     = instr[6:0];
  assign is_lui     = (opcode == OPC_LUI);
  assign is_auipc   = (opcode == OPC_AUIPC);
  assign is_jal     = (opcode == OPC_JAL);
  assign is_jalr    = (opcode == OPC_JALR);
  assign is_branch  = (opcode == OPC_BRANCH);
  assign is_load    = (opcode == OPC_LOAD);
  assign is_store   = (opcode == OPC_STORE);
  assign is_opimm   = (opcode == OPC_OPIMM);
  assign is_op      = (opcode == OPC_OP);
  assign is_legal   = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                      is_load | is_store | is_opimm | is_op;
  assign rd_nonzero = (instr[11:7] != 5'd0);
  assign unused_instr = ^instr[31:12];

  // Next-state logic; the wait counter only advances while a memory request stalls.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH, S_MEM: begin
        if (mem_ready) begin
          state_d = (state_q == S_FETCH) ? S_DECODE : S_WB;
        end else if ((MAX_WAIT != 0) && (wait_q == WAIT_LAST)) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        taken_d = br_taken;
        state_d = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Outputs are decoded from the registered state; reset forces everything low.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = 1'b0;
    ir_we         = 1'b0;
    alu_a_sel     = 2'd0;
    alu_b_sel     = 1'b0;
    alu_force_add = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 2'd0;
    rf_we         = 1'b0;
    wb_sel        = 2'd0;
    retire        = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        S_EXEC: begin
          if (is_lui) begin
            alu_a_sel = 2'd2;
          end else if (is_auipc || is_jal || is_branch) begin
            alu_a_sel = 2'd1;
          end
          alu_b_sel     = !is_op;
          alu_force_add = !(is_op || is_opimm);
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = is_store;
        end
        S_WB: begin
          pc_we  = 1'b1;
          retire = 1'b1;
          if (is_jal || (is_branch && taken_q)) begin
            pc_sel = 2'd1;
          end else if (is_jalr) begin
            pc_sel = 2'd2;
          end
          rf_we = rd_nonzero && (is_op || is_opimm || is_lui || is_auipc ||
                                 is_load || is_jal || is_jalr);
          if (is_load) begin
            wb_sel = 2'd1;
          end else if (is_jal || is_jalr) begin
            wb_sel = 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  assign illegal = !rst && illegal_q;
  assign bus_err = !rst && bus_err_q;
  assign state   = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb/tb_rv_multicycle_ctrl.sv - self-checking bench for rv_multicycle_ctrl
// Drives directed and random instruction streams and checks every cycle against a phase-level model.

module tb_rv_multicycle_ctrl;

  localparam int MAX_WAIT = 4;

  localparam int PH_RESET  = 0;
  localparam int PH_FETCH  = 1;
  localparam int PH_DECODE = 2;
  localparam int PH_EXEC   = 3;
  localparam int PH_MEM    = 4;
  localparam int PH_WB     = 5;
  localparam int PH_TRAP   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        mem_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel, alu_force_add, pc_we;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        retire, illegal, bus_err;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;

  rv_multicycle_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_force_add(alu_force_add),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .retire(retire), .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  logic [19:0] got;
  assign got = {mem_req, mem_we, addr_sel, ir_we, alu_a_sel, alu_b_sel, alu_force_add,
                pc_we, pc_sel, rf_we, wb_sel, retire, illegal, bus_err, state};

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal_op(input logic [31:0] ins);
    return ins[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
  endfunction

  function automatic logic uses_mem(input logic [31:0] ins);
    return ins[6:0] inside {7'b0000011, 7'b0100011};
  endfunction

  // Expected outputs for one cycle, built from the per-phase rules and per-opcode tables.
  function automatic logic [19:0] expect_out(input int ph, input logic [31:0] ins,
                                             input logic rdy, input logic tk,
                                             input logic ill, input logic be);
    logic mr, mw, asel, irw, bsel, fadd, pcw, rfw, ret, il, bu;
    logic [1:0] a, pcs, wbs;
    logic [2:0] st;
    logic [6:0] op;
    op = ins[6:0];
    {mr, mw, asel, irw, bsel, fadd, pcw, rfw, ret, il, bu} = '0;
    a = 2'd0; pcs = 2'd0; wbs = 2'd0; st = 3'd0;
    case (ph)
      PH_FETCH: begin mr = 1'b1; irw = rdy; st = 3'd0; end
      PH_DECODE: st = 3'd1;
      PH_EXEC: begin
        st = 3'd2;
        case (op)
          7'b0110011: begin a = 2'd0; bsel = 1'b0; fadd = 1'b0; end
          7'b0010011: begin a = 2'd0; bsel = 1'b1; fadd = 1'b0; end
          7'b0000011, 7'b0100011, 7'b1100111: begin a = 2'd0; bsel = 1'b1; fadd = 1'b1; end
          7'b0110111: begin a = 2'd2; bsel = 1'b1; fadd = 1'b1; end
          default:    begin a = 2'd1; bsel = 1'b1; fadd = 1'b1; end
        endcase
      end
      PH_MEM: begin st = 3'd3; mr = 1'b1; asel = 1'b1; mw = (op == 7'b0100011); end
      PH_WB: begin
        st = 3'd4; pcw = 1'b1; ret = 1'b1;
        case (op)
          7'b1101111: begin pcs = 2'd1; wbs = 2'd2; rfw = 1'b1; end
          7'b1100111: begin pcs = 2'd2; wbs = 2'd2; rfw = 1'b1; end
          7'b1100011: pcs = tk ? 2'd1 : 2'd0;
          7'b0000011: begin wbs = 2'd1; rfw = 1'b1; end
          7'b0100011: rfw = 1'b0;
          default:    rfw = 1'b1;
        endcase
        if (ins[11:7] == 5'd0) rfw = 1'b0;
      end
      PH_TRAP: begin st = 3'd7; il = ill; bu = be; end
      default: ;
    endcase
    return {mr, mw, asel, irw, a, bsel, fadd, pcw, pcs, rfw, wbs, ret, il, bu, st};
  endfunction

  task automatic step(input logic r, input logic rdy, input logic br, input logic [31:0] ins);
    @(posedge clk);
    #2;
    rst = r; mem_ready = rdy; br_taken = br; instr = ins;
    #2;
  endtask

  task automatic check(input string tag, input logic [19:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%05h exp=%05h state=%0d", tag, got, exp, state);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, rbit(), rbit(), $urandom());
      check("reset_zero", expect_out(PH_RESET, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic trap_hold(input int n, input logic ill, input logic be, input logic [31:0] ins);
    for (int i = 0; i < n; i++) begin
      step(1'b0, rbit(), rbit(), ins);
      check("trap_hold", expect_out(PH_TRAP, ins, 1'b0, 1'b0, ill, be));
    end
  endtask

  // One instruction from FETCH to WB (or into TRAP); trapped reports which trap, 0 = none.
  task automatic run_instr(input string tag, input logic [31:0] ins, input int fw,
                           input int mw, input logic br, output int trapped);
    logic rdy;
    trapped = 0;
    for (int i = 0; i <= fw; i++) begin
      if (i == MAX_WAIT) begin
        step(1'b0, rbit(), rbit(), ins);
        check({tag, "_fetch_timeout"}, expect_out(PH_TRAP, ins, 1'b0, 1'b0, 1'b0, 1'b1));
        trapped = 2;
        return;
      end
      rdy = (i == fw);
      step(1'b0, rdy, rbit(), ins);
      check({tag, "_fetch"}, expect_out(PH_FETCH, ins, rdy, 1'b0, 1'b0, 1'b0));
    end
    step(1'b0, rbit(), rbit(), ins);
    check({tag, "_decode"}, expect_out(PH_DECODE, ins, 1'b0, 1'b0, 1'b0, 1'b0));
    if (!legal_op(ins)) begin
      step(1'b0, rbit(), rbit(), ins);
      check({tag, "_illegal"}, expect_out(PH_TRAP, ins, 1'b0, 1'b0, 1'b1, 1'b0));
      trapped = 1;
      return;
    end
    step(1'b0, rbit(), br, ins);
    check({tag, "_exec"}, expect_out(PH_EXEC, ins, 1'b0, 1'b0, 1'b0, 1'b0));
    if (uses_mem(ins)) begin
      for (int i = 0; i <= mw; i++) begin
        if (i == MAX_WAIT) begin
          step(1'b0, rbit(), rbit(), ins);
          check({tag, "_mem_timeout"}, expect_out(PH_TRAP, ins, 1'b0, 1'b0, 1'b0, 1'b1));
          trapped = 2;
          return;
        end
        rdy = (i == mw);
        step(1'b0, rdy, rbit(), ins);
        check({tag, "_mem"}, expect_out(PH_MEM, ins, rdy, 1'b0, 1'b0, 1'b0));
      end
    end
    step(1'b0, rbit(), ~br, ins);
    check({tag, "_wb"}, expect_out(PH_WB, ins, 1'b0, br, 1'b0, 1'b0));
  endtask

  initial begin
    int tr;
    logic [31:0] r;
    logic [6:0] opc_tab [10];
    opc_tab = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111};

    do_reset(3);

    run_instr("addi",    32'h00C00093, 0, 0, 1'b0, tr);
    run_instr("lw_wait", 32'h00402083, 0, 3, 1'b0, tr);
    run_instr("sw",      32'h00102223, 0, 0, 1'b0, tr);
    run_instr("addi_x0", 32'h00C00013, 0, 0, 1'b0, tr);
    run_instr("beq_t",   32'h00100463, 0, 0, 1'b1, tr);
    run_instr("beq_nt",  32'h00100463, 0, 0, 1'b0, tr);
    run_instr("jal",     32'h008000EF, 0, 0, 1'b0, tr);
    run_instr("jalr",    32'h008000E7, 0, 0, 1'b0, tr);
    run_instr("fstall3", 32'h00C00093, 3, 0, 1'b0, tr);

    run_instr("illegal", 32'h00000000, 0, 0, 1'b0, tr);
    trap_hold(20, 1'b1, 1'b0, 32'h00000000);
    do_reset(2);
    run_instr("post_ill", 32'h00C00093, 0, 0, 1'b0, tr);

    run_instr("wd_fetch", 32'h00C00093, 9, 0, 1'b0, tr);
    trap_hold(5, 1'b0, 1'b1, 32'h00C00093);
    do_reset(2);

    run_instr("wd_mem", 32'h00402083, 1, 9, 1'b0, tr);
    trap_hold(3, 1'b0, 1'b1, 32'h00402083);
    do_reset(2);

    step(1'b0, 1'b1, 1'b0, 32'h00402083);
    check("abort_fetch", expect_out(PH_FETCH, 32'h00402083, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 32'h00402083);
    check("abort_decode", expect_out(PH_DECODE, 32'h00402083, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 32'h00402083);
    check("abort_exec", expect_out(PH_EXEC, 32'h00402083, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 32'h00402083);
    check("abort_mem", expect_out(PH_MEM, 32'h00402083, 1'b0, 1'b0, 1'b0, 1'b0));
    do_reset(2);
    run_instr("post_abort", 32'h00402083, 0, 0, 1'b0, tr);

    for (int n = 0; n < 80; n++) begin
      r = $urandom();
      r[6:0] = opc_tab[$urandom_range(0, 9)];
      run_instr("rand", r, $urandom_range(0, 5), $urandom_range(0, 5), rbit(), tr);
      if (tr != 0) begin
        trap_hold(2, tr == 1, tr == 2, r);
        do_reset(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
